// File: rtl/alu16.sv
// ---------------------------------------------------------------------------
// alu16 - 16-bit registered ALU with a five-bit flag register.
//
// Every cycle the combinational datapath computes a result and next-flag
// value from A, B, Op and cin. Both are captured on the rising clk edge, so a
// result appears one cycle after its operands. There is no handshake: valid
// is implicitly high every cycle, and the ALU never back-pressures. A new
// operation may therefore be issued on every clock.
//
// Ports
//   clk    : sole clock, rising edge
//   rst_n  : asynchronous active-low reset; clears Output and Flags
//   A      : first operand (destination role)
//   B      : second operand (source role / shift amount)
//   Op     : opcode
//   cin    : carry-in, consumed only by ADDC
//   Output : registered 16-bit result
//   Flags  : registered flags {N, Z, F, L, C} = bits [4:0]
// ---------------------------------------------------------------------------
module alu16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [7:0]  Op,
    input  logic        cin,
    output logic [15:0] Output,
    output logic [4:0]  Flags
);

    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_ADDC = 8'h07;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_LSH  = 8'h84;
    localparam logic [7:0] OP_ASHU = 8'h86;

    // Flag bit positions inside Flags.
    localparam int FL_C = 0;
    localparam int FL_L = 1;
    localparam int FL_F = 2;
    localparam int FL_Z = 3;
    localparam int FL_N = 4;

    logic        carry_in;
    logic [16:0] add_sum;   // bit 16 is the unsigned carry-out
    logic [16:0] sub_diff;  // A - B, bit 16 is the unsigned borrow
    logic [16:0] cmp_diff;  // B - A; CMP compares the source against the destination
    logic [15:0] neg_b;     // magnitude of a negative ASHU shift amount
    logic [15:0] next_out;
    logic [4:0]  next_flags;

    assign carry_in = (Op == OP_ADDC) ? cin : 1'b0;
    assign add_sum  = {1'b0, A} + {1'b0, B} + {16'd0, carry_in};
    assign sub_diff = {1'b0, A} - {1'b0, B};
    assign cmp_diff = {1'b0, B} - {1'b0, A};
    assign neg_b    = 16'd0 - B;

    always_comb begin
        next_out   = 16'h0000;
        next_flags = Flags;  // any flag an opcode does not write keeps its value
        case (Op)
            OP_AND: next_out = A & B;
            OP_OR:  next_out = A | B;
            OP_XOR: next_out = A ^ B;
            OP_ADD, OP_ADDC: begin
                next_out         = add_sum[15:0];
                next_flags[FL_C] = add_sum[16];
                // Overflow: operands agree in sign but the result does not.
                next_flags[FL_F] = (A[15] == B[15]) && (add_sum[15] != A[15]);
            end
            OP_SUB: begin
                next_out         = sub_diff[15:0];
                next_flags[FL_C] = sub_diff[16];
                next_flags[FL_F] = (A[15] != B[15]) && (sub_diff[15] != A[15]);
            end
            OP_CMP: begin
                next_out         = 16'h0000;
                next_flags[FL_Z] = (A == B);
                next_flags[FL_L] = cmp_diff[16];  // borrow of B - A means B < A unsigned
                next_flags[FL_N] = ($signed(B) < $signed(A));
                next_flags[FL_F] = (B[15] != A[15]) && (cmp_diff[15] != B[15]);
            end
            OP_LSH: begin
                // Any amount with bits above bit 3 set shifts everything out.
                if (B[15:4] == 12'd0)
                    next_out = A << B[3:0];
                else
                    next_out = 16'h0000;
            end
            OP_ASHU: begin
                if (!B[15]) begin
                    if (B[15:4] == 12'd0)
                        next_out = A << B[3:0];
                    else
                        next_out = 16'h0000;
                end else begin
                    // For B = 0x8000 the negation is 0x8000 again; its upper
                    // bits are set, so it correctly falls into sign fill.
                    if (neg_b[15:4] == 12'd0)
                        next_out = 16'($signed(A) >>> neg_b[3:0]);
                    else
                        next_out = {16{A[15]}};
                end
            end
            default: next_out = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Output <= 16'h0000;
            Flags  <= 5'b00000;
        end else begin
            Output <= next_out;
            Flags  <= next_flags;
        end
    end

endmodule

// File: tb/tb_alu16.sv
// ---------------------------------------------------------------------------
// tb_alu16 - directed bench for alu16.
//
// A behavioural model computes result and flags with plain integer
// arithmetic; a compare process checks the DUT against it on every falling
// edge. Literal expectations at selected points pin the model itself.
// ---------------------------------------------------------------------------
module tb_alu16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic [7:0]  op = 8'h00;
    logic        cin = 1'b0;
    logic [15:0] dut_out;
    logic [4:0]  dut_flags;

    int checks = 0;
    int errors = 0;
    bit compare_en = 1'b0;

    logic [15:0] model_out;
    logic [4:0]  model_flags;

    alu16 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (a),
        .B      (b),
        .Op     (op),
        .cin    (cin),
        .Output (dut_out),
        .Flags  (dut_flags)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Returns {flags, result}, given the flags held before the operation.
    function automatic logic [20:0] model_step(input logic [7:0] mop, input logic [15:0] ma,
                                               input logic [15:0] mb, input logic mc,
                                               input logic [4:0] fin);
        int ua, ub, sa, sb, t, n;
        logic [15:0] r;
        logic [4:0]  f;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        f  = fin;
        r  = 16'h0000;
        case (mop)
            8'h01: r = ma & mb;
            8'h02: r = ma | mb;
            8'h03: r = ma ^ mb;
            8'h05, 8'h07: begin
                t    = ua + ub + ((mop == 8'h07) ? int'(mc) : 0);
                r    = 16'(t);
                f[0] = (t > 65535);
                t    = sa + sb + ((mop == 8'h07) ? int'(mc) : 0);
                f[2] = (t > 32767) || (t < -32768);
            end
            8'h09: begin
                r    = 16'(ua - ub);
                f[0] = (ua < ub);
                t    = sa - sb;
                f[2] = (t > 32767) || (t < -32768);
            end
            8'h0B: begin
                r    = 16'h0000;
                f[3] = (ua == ub);
                f[1] = (ub < ua);
                f[4] = (sb < sa);
                t    = sb - sa;
                f[2] = (t > 32767) || (t < -32768);
            end
            8'h84: r = (ub >= 16) ? 16'h0000 : 16'(ua << ub);
            8'h86: begin
                if (sb >= 0) begin
                    r = (sb >= 16) ? 16'h0000 : 16'(ua << sb);
                end else begin
                    n = -sb;
                    if (n >= 16) r = (sa < 0) ? 16'hFFFF : 16'h0000;
                    else         r = 16'(sa >>> n);
                end
            end
            default: r = 16'h0000;
        endcase
        return {f, r};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_out   <= 16'h0000;
            model_flags <= 5'b00000;
        end else begin
            {model_flags, model_out} <= model_step(op, a, b, cin, model_flags);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (compare_en) begin
            checks = checks + 1;
            if (dut_out !== model_out) begin
                errors = errors + 1;
                $display("FAIL model_out t=%0t op=%h: got %h expected %h", $time, op, dut_out, model_out);
            end
            checks = checks + 1;
            if (dut_flags !== model_flags) begin
                errors = errors + 1;
                $display("FAIL model_flags t=%0t op=%h: got %b expected %b", $time, op, dut_flags, model_flags);
            end
        end
    end

    // ---------------- driver / literal checks ----------------
    task automatic apply(input logic [7:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic c);
        op  = o;
        a   = x;
        b   = y;
        cin = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [15:0] exp_v);
        checks = checks + 1;
        if (dut_out !== exp_v) begin
            errors = errors + 1;
            $display("FAIL %s: Output got %h expected %h", name, dut_out, exp_v);
        end
    endtask

    task automatic check_flags(input string name, input logic [4:0] exp_v);
        checks = checks + 1;
        if (dut_flags !== exp_v) begin
            errors = errors + 1;
            $display("FAIL %s: Flags got %b expected %b", name, dut_flags, exp_v);
        end
    endtask

    initial begin
        // Reset from a known high level so the falling edge is seen.
        #2 rst_n = 1'b0;
        #1;
        check_out("reset_out", 16'h0000);
        check_flags("reset_flags", 5'b00000);
        @(posedge clk);
        #1;
        check_out("reset_hold_out", 16'h0000);
        rst_n = 1'b1;
        compare_en = 1'b1;

        // Arithmetic
        apply(8'h05, 16'hFFFF, 16'h0064, 1'b0);
        check_out("add_wrap", 16'h0063);
        check_flags("add_wrap_flags", 5'b00001);
        apply(8'h05, 16'hFF9B, 16'h0064, 1'b0);
        check_out("add_nowrap", 16'hFFFF);
        check_flags("add_nowrap_flags", 5'b00000);

        // Compare (C stays 0 from the previous ADD)
        apply(8'h0B, 16'd12, 16'd10, 1'b0);
        check_out("cmp_12_10", 16'h0000);
        check_flags("cmp_12_10_flags", 5'b10010);
        apply(8'h0B, 16'd3, 16'd3, 1'b0);
        check_flags("cmp_eq_flags", 5'b01000);
        apply(8'h0B, 16'd12, 16'hFFF6, 1'b0);
        check_flags("cmp_neg_flags", 5'b10000);

        // Logic ops leave N from the last CMP intact
        apply(8'h01, 16'd40, 16'd100, 1'b0);
        check_out("and", 16'h0020);
        apply(8'h02, 16'hFFFF, 16'd10000, 1'b0);
        check_out("or", 16'hFFFF);
        apply(8'h03, 16'd40, 16'd100, 1'b0);
        check_out("xor", 16'h004C);
        apply(8'h03, 16'd100, 16'd100, 1'b0);
        check_out("xor_self", 16'h0000);
        check_flags("logic_flags_kept", 5'b10000);

        // Shifts
        apply(8'h84, 16'h0021, 16'd5, 1'b0);
        check_out("lsh5", 16'h0420);
        apply(8'h84, 16'h1021, 16'd8, 1'b0);
        check_out("lsh8", 16'h2100);
        apply(8'h84, 16'h0001, 16'd16, 1'b0);
        check_out("lsh16", 16'h0000);
        apply(8'h84, 16'h0001, 16'hFFFF, 1'b0);
        check_out("lsh_ffff", 16'h0000);
        apply(8'h86, 16'h1021, 16'd0, 1'b0);
        check_out("ashu0", 16'h1021);
        apply(8'h86, 16'h1021, 16'd1, 1'b0);
        check_out("ashu1", 16'h2042);
        apply(8'h86, 16'h1021, 16'd7, 1'b0);
        check_out("ashu7", 16'h1080);
        apply(8'h86, 16'h8000, 16'hFFFF, 1'b0);
        check_out("ashu_m1", 16'hC000);
        apply(8'h86, 16'h8000, 16'hFFF0, 1'b0);
        check_out("ashu_m16", 16'hFFFF);
        apply(8'h86, 16'h4000, 16'hFFF0, 1'b0);
        check_out("ashu_m16_pos", 16'h0000);
        apply(8'h86, 16'h8001, 16'h8000, 1'b0);
        check_out("ashu_m32768", 16'hFFFF);
        apply(8'h86, 16'h4321, 16'hFFFC, 1'b0);
        check_out("ashu_m4", 16'h0432);
        apply(8'h86, 16'h0001, 16'd16, 1'b0);
        check_out("ashu16", 16'h0000);
        check_flags("shift_flags_kept", 5'b10000);

        // Subtract / overflow / carry-in
        apply(8'h09, 16'd5, 16'd7, 1'b0);
        check_out("sub_borrow", 16'hFFFE);
        check_flags("sub_borrow_flags", 5'b10001);
        apply(8'h09, 16'h8000, 16'h0001, 1'b0);
        check_out("sub_ovf", 16'h7FFF);
        check_flags("sub_ovf_flags", 5'b10100);
        apply(8'h05, 16'h7FFF, 16'h0001, 1'b0);
        check_out("add_ovf", 16'h8000);
        check_flags("add_ovf_flags", 5'b10100);
        apply(8'h07, 16'hFFFF, 16'h0000, 1'b1);
        check_out("addc_cin", 16'h0000);
        check_flags("addc_cin_flags", 5'b10001);
        apply(8'h05, 16'hFFFF, 16'h0000, 1'b1);
        check_out("add_ignores_cin", 16'hFFFF);
        apply(8'h04, 16'h1234, 16'h5678, 1'b0);
        check_out("undef_op", 16'h0000);
        check_flags("undef_flags", 5'b10000);

        // Back-to-back random ops, checked by the model only
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 8))
                0: op = 8'h01; 1: op = 8'h02; 2: op = 8'h03;
                3: op = 8'h05; 4: op = 8'h07; 5: op = 8'h09;
                6: op = 8'h0B; 7: op = 8'h84; default: op = 8'h86;
            endcase
            apply(op, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)));
        end

        // Asynchronous reset between edges
        apply(8'h05, 16'hFFFF, 16'h0002, 1'b0);
        check_out("pre_reset", 16'h0001);
        op = 8'h05;
        a  = 16'hFFFF;
        b  = 16'h0003;
        #1 rst_n = 1'b0;
        #1;
        check_out("async_reset_out", 16'h0000);
        check_flags("async_reset_flags", 5'b00000);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_out("post_reset_out", 16'h0002);
        check_flags("post_reset_flags", 5'b00001);

        @(posedge clk);
        #1;
        compare_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
